thread_return_dispatcher: RTL
=============================

Name: thread_return_dispatcher

Overview:
Sits directly upstream of the organization stage. It buffers tagged memory read returns in one slot per thread and selects one ready thread per cycle round-robin. It drives the organization stage's active, thread_id and data_return inputs so a thread issues only when its read data is present. Thread register contents are looked up elsewhere by the emitted thread_id.

Parameters:
NUM_THREADS, 16, number of hardware threads and buffer slots
ID_W, 4, thread id width, equal to clog2(NUM_THREADS)
DATA_W, 512, read-return payload width (16 x u32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ret_valid  in  1  read return present this cycle
ret_id  in  ID_W  receive_id (owning thread) of the return
ret_data  in  DATA_W  return payload
hold  in  1  downstream freeze; no dispatch while high
active  out  1  a thread is issued this cycle
thread_id  out  ID_W  issued thread
dr_valid  out  1  data_return.valid to the organization stage
dr_receive_id  out  ID_W  data_return.receive_id, equal to thread_id when active
dr_data  out  DATA_W  data_return.data
pending_count  out  ID_W+1  number of occupied slots (registered)
ret_error  out  1  sticky error flag

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset, including mid-operation: all slots empty, rr_ptr=0, every output 0, ret_error=0. Returns arriving in the reset cycle are discarded.
- Storage: per slot k, a valid bit and DATA_W of data.
  - On a rising edge with ret_valid=1 and ret_id<NUM_THREADS, slot[ret_id] is written and its valid bit set.
- Dispatch, evaluated each edge when hold=0:
  - Candidate k is the first valid slot searching rr_ptr, rr_ptr+1, ..., wrapping N-1 to 0.
  - If a candidate is found, at the same edge: active=1, thread_id=k, dr_valid=1, dr_receive_id=k, dr_data=slot[k].data. Slot k is cleared and rr_ptr = (k+1) mod NUM_THREADS.
  - If no candidate is found: active, dr_valid, thread_id, dr_receive_id and dr_data all drive 0, and rr_ptr is unchanged.
- Outputs are registered and held for exactly one cycle per dispatch.
- Latency: a return captured at edge t can dispatch at edge t+1 at the earliest. Minimum return-to-active latency is 2 edges. There is no bypass.
- hold=1:
  - Outputs are forced to 0 at the next edge.
  - Slots and rr_ptr are retained.
  - Returns continue to be captured.
  - On release, dispatch resumes at the next edge.
- Collision:
  - A return to a slot that is already valid and not being dispatched at that edge sets ret_error=1. The new data is dropped and the old data kept.
  - A return to slot k at the same edge that slot k is dispatched is legal. Old data is dispatched, and the slot is refilled with the new data and remains valid.
- ret_id>=NUM_THREADS (possible only when NUM_THREADS is not a power of two): ignored, sets ret_error.
- ret_error clears only on rst.
- pending_count: occupied slots after the edge's writes and clears; it never exceeds NUM_THREADS.
- At most one dispatch and one capture per cycle. With continuous returns to distinct empty slots, throughput is 1 thread per cycle.

Test Plan:
- Reset: rst=1 for 1 edge with ret_valid=1, ret_id=3 -> all outputs 0, pending_count=0. After rst=0, slot 3 is not dispatched.
- Single return: ret_id=10, ret_data word[10]=6 at edge t, hold=0 -> at edge t+1 active=1, thread_id=10, dr_receive_id=10, dr_data word[10]=6. At edge t+2 active=0, pending_count=0.
- Round-robin wrap: hold=1, load ids 1,3,5 -> pending_count=3. Release -> dispatch order 1,3,5. Then load 0 and 6 with rr_ptr=6 -> order 6 then 0.
- Hold: slot 2 full, hold=1 for 4 cycles -> active=0 throughout, pending_count=1. hold=0 -> thread 2 issued next edge.
- Collision: hold=1, return id 7 data A, then id 7 data B -> ret_error=1. Release -> dispatch 7 with A, pending_count=0, ret_error stays 1.
- Same-edge refill: slot 4 valid with A, dispatched at an edge where a return id 4 with B arrives -> issue A, ret_error=0. Next edge issues 4 with B (provided no other slots are pending).

Source files
------------

// File: rtl/thread_return_dispatcher.sv
// thread_return_dispatcher
// Buffers tagged memory read returns in one slot per thread and issues one
// ready thread per cycle in round-robin order to the organization stage.
// A thread is only issued once its read data is sitting in its slot.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   ret_valid      read return present this cycle
//   ret_id         owning thread of the return
//   ret_data       return payload
//   hold           downstream freeze, no dispatch while high
//   active         a thread is issued this cycle (registered)
//   thread_id      issued thread (registered)
//   dr_valid       data_return.valid, mirrors active
//   dr_receive_id  data_return.receive_id, mirrors thread_id
//   dr_data        data_return.data of the issued thread (registered)
//   pending_count  occupied slots after this edge's writes and clears
//   ret_error      sticky: collision on a full slot or out-of-range id
module thread_return_dispatcher #(
   parameter int NUM_THREADS = 16,
   parameter int ID_W        = 4,
   parameter int DATA_W      = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ret_valid,
   input  logic [ID_W-1:0]   ret_id,
   input  logic [DATA_W-1:0] ret_data,
   input  logic              hold,
   output logic              active,
   output logic [ID_W-1:0]   thread_id,
   output logic              dr_valid,
   output logic [ID_W-1:0]   dr_receive_id,
   output logic [DATA_W-1:0] dr_data,
   output logic [ID_W:0]     pending_count,
   output logic              ret_error
);

   localparam logic [ID_W:0]   NUM_T   = (ID_W+1)'(NUM_THREADS);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_THREADS - 1);

   logic [NUM_THREADS-1:0] slot_valid_reg;
   logic [NUM_THREADS-1:0] slot_valid_next;
   logic [DATA_W-1:0]      slot_data [NUM_THREADS];
   logic [ID_W-1:0]        rr_ptr_reg;
   logic [ID_W-1:0]        rr_ptr_next;
   logic [ID_W:0]          pending_next;

   logic                   active_reg;
   logic [ID_W-1:0]        thread_id_reg;
   logic [DATA_W-1:0]      dr_data_reg;
   logic [ID_W:0]          pending_count_reg;
   logic                   ret_error_reg;

   logic                   cand_found;
   logic [ID_W-1:0]        cand_id;
   logic                   dispatch;
   logic                   id_in_range;
   logic                   refill;
   logic                   capture;
   logic                   bad_return;

   // Round-robin search. Walking offsets from farthest to nearest lets the
   // slot closest to rr_ptr overwrite any earlier hit, so it wins.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] probe;
      cand_found = 1'b0;
      cand_id    = '0;
      idx        = 0;
      probe      = '0;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= NUM_THREADS) begin
            idx = idx - NUM_THREADS;
         end
         probe = ID_W'(idx);
         if (slot_valid_reg[probe]) begin
            cand_found = 1'b1;
            cand_id    = probe;
         end
      end
   end

   assign dispatch    = !hold && cand_found;
   assign id_in_range = {1'b0, ret_id} < NUM_T;
   // A return may land in a full slot only when that slot empties at this edge.
   assign refill      = dispatch && (cand_id == ret_id);
   assign capture     = ret_valid && id_in_range && (!slot_valid_reg[ret_id] || refill);
   assign bad_return  = ret_valid && !capture;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_THREADS; gi++) begin : g_slot
         // Capture has priority over the dispatch clear so a same-edge refill
         // leaves the slot valid.
         assign slot_valid_next[gi] =
            (capture && (ret_id == ID_W'(gi))) ||
            (slot_valid_reg[gi] && !(dispatch && (cand_id == ID_W'(gi))));
      end
   endgenerate

   always_comb begin
      pending_next = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         pending_next = pending_next + (ID_W+1)'(slot_valid_next[i]);
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (dispatch) begin
         rr_ptr_next = (cand_id == LAST_ID) ? '0 : cand_id + 1'b1;
      end
   end

   // Payload storage has no reset; the valid bits alone define occupancy.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         slot_data[ret_id] <= ret_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid_reg    <= '0;
         rr_ptr_reg        <= '0;
         active_reg        <= 1'b0;
         thread_id_reg     <= '0;
         dr_data_reg       <= '0;
         pending_count_reg <= '0;
         ret_error_reg     <= 1'b0;
      end else begin
         slot_valid_reg    <= slot_valid_next;
         rr_ptr_reg        <= rr_ptr_next;
         active_reg        <= dispatch;
         thread_id_reg     <= dispatch ? cand_id : '0;
         // Reads the pre-edge contents, so a same-edge refill issues old data.
         dr_data_reg       <= dispatch ? slot_data[cand_id] : '0;
         pending_count_reg <= pending_next;
         if (bad_return) begin
            ret_error_reg <= 1'b1;
         end
      end
   end

   assign active        = active_reg;
   assign thread_id     = thread_id_reg;
   assign dr_valid      = active_reg;
   assign dr_receive_id = thread_id_reg;
   assign dr_data       = dr_data_reg;
   assign pending_count = pending_count_reg;
   assign ret_error     = ret_error_reg;

endmodule
